zoom_ctrl_hist: RTL and testbench
=================================

Name: zoom_ctrl_hist

Overview:
Parametrised successor to the single-step zoom controller. It accepts zoom-in, zoom-out and return requests from debounced buttons and validates them against the algorithm select. It tracks the current zoom level and keeps a multi-level undo history (LIFO, depth HIST_DEPTH). It sequences the scaler and RAM write through an IDLE/PROCESS/DONE handshake, with an optional watchdog timeout. It sits between the input conditioning logic and the image scaler core.

Parameters:
LEVEL_W, 3, width of zoom_level
NUM_LEVELS, 5, number of legal levels, 0..NUM_LEVELS-1 (must be <= 2**LEVEL_W)
DEFAULT_LEVEL, 2, level after reset (1.0x)
HIST_DEPTH, 4, undo stack entries (>=1)
TIMEOUT_CYCLES, 0, PROCESS watchdog in cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
zoom_in  in  1  sync level; acted on at rising edge only
zoom_out  in  1  sync level; acted on at rising edge only
return_to_previous  in  1  sync level; acted on at rising edge only
algorithm_select  in  2  00/01 zoom-in algorithms, 10/11 zoom-out algorithms
multiple_switches_error  in  1  blocks acceptance while high
no_switch_selected_error  in  1  blocks acceptance while high
done  in  1  scaler completion, sampled in PROCESS
enable  out  1  scaler enable
wren  out  1  RAM write enable
busy  out  1  high in PROCESS and DONE
zoom_level  out  LEVEL_W  current level
history_count  out  $clog2(HIST_DEPTH+1)  valid undo entries
invalid_zoom_error  out  1  sticky: direction/algorithm mismatch
history_empty_error  out  1  sticky: return requested with empty history
timeout_error  out  1  sticky: watchdog expired
processing_has_run_once  out  1  set on first done

Behaviour:
- Reset values: zoom_level=DEFAULT_LEVEL, history_count=0, state=IDLE, and every other output 0.
- Edge detect: each of the three request inputs is registered once, and edge = in & ~in_q. Edges seen outside IDLE are discarded, not queued.
- Priority when several edges fall in the same cycle: return > zoom_in > zoom_out. Only the highest one is evaluated; the rest are dropped.
- Gate: with multiple_switches_error or no_switch_selected_error high, no request is accepted and no error flag changes.
- Accepted zoom_in: algorithm_select in {00,01} and zoom_level < NUM_LEVELS-1. Push zoom_level, then zoom_level+1.
- Accepted zoom_out: algorithm_select in {10,11} and zoom_level > 0. Push zoom_level, then zoom_level-1.
- Zoom at a limit: zoom_in at the top or zoom_out at 0 is ignored silently, with no error and no push.
- Direction mismatch: zoom_in with select 1x, or zoom_out with select 0x, sets invalid_zoom_error.
- Accepted return: history_count>0. Pop into zoom_level; nothing is pushed.
- Return with history_count==0 sets history_empty_error; the state is unchanged.
- Stack full on push: the oldest entry is overwritten (circular) and history_count saturates at HIST_DEPTH.
- Acceptance timing: zoom_level and the stack update on the accepting edge, and state goes to PROCESS on that same edge. All three sticky errors clear there.
- PROCESS: enable=wren=1, with the first assertion the cycle after acceptance.
  - On done=1: set processing_has_run_once and go to DONE.
  - Watchdog (TIMEOUT_CYCLES>0): counter starts at 0 on entry and increments each cycle. If it reaches TIMEOUT_CYCLES-1 without done, timeout_error is set, zoom_level is restored to its pre-request value, the stack op is undone (pop re-pushed, push dropped), and state goes to IDLE.
  - done and timeout in the same cycle: done wins.
- DONE: one cycle, enable=wren=0, busy=1, then IDLE. Back-to-back minimum period is therefore 3 cycles plus the scaler latency.
- Reset mid-PROCESS: everything returns to reset values immediately (asynchronous), and history is lost.

Decomposition:
- Shared package zoom_ctrl_pkg holds:
  - state encodings S_IDLE/S_PROCESS/S_DONE
  - algorithm select constants ALG_IN_0/1 and ALG_OUT_0/1
  - default parameter values
- One sub-module, zoom_history_stack: a circular LIFO of LEVEL_W x HIST_DEPTH with push/pop/undo ports, count output and overwrite-oldest on full.

Test Plan:
1. Reset, select=00, pulse zoom_in -> zoom_level 2->3, history_count=1, enable high 1 cycle later; done -> DONE 1 cycle, processing_has_run_once=1.
2. Select=00, five zoom_in pulses, each completed -> levels 3,4,4,4,4 (limit ignored, no error), history_count=2; pulse zoom_out with select=00 -> invalid_zoom_error=1, level stays 4.
3. HIST_DEPTH=4: six accepted alternating in/out ops -> history_count=4; five returns -> four pops restore the last four saved levels in LIFO order, fifth sets history_empty_error.
4. zoom_in and return_to_previous rise in the same cycle with history_count=1 -> return wins, level = popped value, history_count=0.
5. TIMEOUT_CYCLES=8, accept zoom_in at level 2 with done held low -> after 8 PROCESS cycles timeout_error=1, zoom_level=2, history_count=0, state IDLE.
6. Assert reset while in PROCESS -> enable/wren/busy drop 0 without a clock edge, zoom_level=2, history_count=0.

Source files
------------

// File: rtl/zoom_ctrl_pkg.sv
// Shared definitions for the zoom controller: state encoding, algorithm
// select codes and default parameter values.
package zoom_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PROCESS = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [1:0] ALG_IN_0  = 2'b00;
   localparam logic [1:0] ALG_IN_1  = 2'b01;
   localparam logic [1:0] ALG_OUT_0 = 2'b10;
   localparam logic [1:0] ALG_OUT_1 = 2'b11;

   localparam int DEF_LEVEL_W        = 3;
   localparam int DEF_NUM_LEVELS     = 5;
   localparam int DEF_DEFAULT_LEVEL  = 2;
   localparam int DEF_HIST_DEPTH     = 4;
   localparam int DEF_TIMEOUT_CYCLES = 0;

   function automatic logic is_zoom_in_alg(input logic [1:0] sel);
      return (sel == ALG_IN_0) || (sel == ALG_IN_1);
   endfunction

   function automatic logic is_zoom_out_alg(input logic [1:0] sel);
      return (sel == ALG_OUT_0) || (sel == ALG_OUT_1);
   endfunction

endpackage

// File: rtl/zoom_history_stack.sv
// Circular LIFO of zoom levels. A push onto a full stack overwrites the
// oldest entry. The most recent push or pop can be undone once.
module zoom_history_stack #(
   parameter int LEVEL_W    = 3,
   parameter int HIST_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            push,
   input  logic                            pop,
   input  logic                            undo,
   input  logic [LEVEL_W-1:0]              push_data,
   output logic [LEVEL_W-1:0]              top_data,
   output logic [$clog2(HIST_DEPTH+1)-1:0] count
);

   localparam int HC_W  = $clog2(HIST_DEPTH + 1);
   localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam logic [HC_W-1:0]  FULL     = HC_W'(HIST_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(HIST_DEPTH - 1);

   logic [LEVEL_W-1:0] mem [HIST_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   saved_ptr;
   logic [HC_W-1:0]    saved_count;
   logic [LEVEL_W-1:0] saved_data;
   logic               last_push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
      return (p == '0) ? LAST_PTR : p - PTR_W'(1);
   endfunction

   // Pointer/count bookkeeping; snapshot taken on every op so undo can restore it
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         count       <= '0;
         saved_ptr   <= '0;
         saved_count <= '0;
         saved_data  <= '0;
         last_push   <= 1'b0;
      end else if (push) begin
         saved_ptr   <= wr_ptr;
         saved_count <= count;
         saved_data  <= mem[wr_ptr];
         last_push   <= 1'b1;
         wr_ptr      <= ptr_inc(wr_ptr);
         if (count != FULL) count <= count + HC_W'(1);
      end else if (pop) begin
         saved_ptr   <= wr_ptr;
         saved_count <= count;
         last_push   <= 1'b0;
         wr_ptr      <= ptr_dec(wr_ptr);
         count       <= count - HC_W'(1);
      end else if (undo) begin
         wr_ptr <= saved_ptr;
         count  <= saved_count;
      end
   end

   // Storage write; undoing a push puts back the entry it overwrote
   // NOTE: the storage array has no reset; an empty stack is defined by count,
   // so stale contents are never observed and the array can map to RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
      else if (undo && last_push)
         mem[saved_ptr] <= saved_data;
   end

   assign top_data = mem[ptr_dec(wr_ptr)];

endmodule

// File: rtl/zoom_ctrl_hist.sv
// Zoom controller with multi-level undo history. Validates debounced zoom
// requests, tracks the zoom level and sequences the scaler through an
// IDLE/PROCESS/DONE handshake with an optional PROCESS watchdog.
module zoom_ctrl_hist
   import zoom_ctrl_pkg::*;
#(
   parameter int LEVEL_W        = DEF_LEVEL_W,
   parameter int NUM_LEVELS     = DEF_NUM_LEVELS,
   parameter int DEFAULT_LEVEL  = DEF_DEFAULT_LEVEL,
   parameter int HIST_DEPTH     = DEF_HIST_DEPTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            zoom_in,
   input  logic                            zoom_out,
   input  logic                            return_to_previous,
   input  logic [1:0]                      algorithm_select,
   input  logic                            multiple_switches_error,
   input  logic                            no_switch_selected_error,
   input  logic                            done,
   output logic                            enable,
   output logic                            wren,
   output logic                            busy,
   output logic [LEVEL_W-1:0]              zoom_level,
   output logic [$clog2(HIST_DEPTH+1)-1:0] history_count,
   output logic                            invalid_zoom_error,
   output logic                            history_empty_error,
   output logic                            timeout_error,
   output logic                            processing_has_run_once
);

   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]    WD_LAST   = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [LEVEL_W-1:0] TOP_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
   localparam logic [LEVEL_W-1:0] RST_LEVEL = LEVEL_W'(DEFAULT_LEVEL);

   state_t             state, state_nxt;
   logic               zoom_in_q, zoom_out_q, return_q;
   logic               ev_in, ev_out, ev_ret;
   logic               acc_in, acc_out, acc_ret, accept;
   logic               mismatch, empty_req, timeout_hit;
   logic [WD_W-1:0]    wd_cnt;
   logic [LEVEL_W-1:0] prev_level;
   logic [LEVEL_W-1:0] top_data;

   // Register request inputs once for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zoom_in_q  <= 1'b0;
         zoom_out_q <= 1'b0;
         return_q   <= 1'b0;
      end else begin
         zoom_in_q  <= zoom_in;
         zoom_out_q <= zoom_out;
         return_q   <= return_to_previous;
      end
   end

   // Select the single highest-priority edge seen in IDLE with the gate open
   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      ev_in  = 1'b0;
      ev_out = 1'b0;
      ev_ret = 1'b0;
      if (state == S_IDLE && !multiple_switches_error && !no_switch_selected_error) begin
         if (return_to_previous && !return_q)
            ev_ret = 1'b1;
         else if (zoom_in && !zoom_in_q)
            ev_in = 1'b1;
         else if (zoom_out && !zoom_out_q)
            ev_out = 1'b1;
      end
   end

   assign acc_in      = ev_in  && is_zoom_in_alg(algorithm_select)  && (zoom_level < TOP_LEVEL);
   assign acc_out     = ev_out && is_zoom_out_alg(algorithm_select) && (zoom_level != '0);
   assign acc_ret     = ev_ret && (history_count != '0);
   assign accept      = acc_in || acc_out || acc_ret;
   assign mismatch    = (ev_in && !is_zoom_in_alg(algorithm_select)) ||
                        (ev_out && !is_zoom_out_alg(algorithm_select));
   assign empty_req   = ev_ret && (history_count == '0);
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == S_PROCESS) && !done &&
                        (wd_cnt == WD_LAST);

   zoom_history_stack #(
      .LEVEL_W    (LEVEL_W),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk       (clk),
      .reset     (reset),
      .push      (acc_in || acc_out),
      .pop       (acc_ret),
      .undo      (timeout_hit),
      .push_data (zoom_level),
      .top_data  (top_data),
      .count     (history_count)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; done takes precedence over the watchdog
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = S_PROCESS;
         S_PROCESS: begin
            if (done)             state_nxt = S_DONE;
            else if (timeout_hit) state_nxt = S_IDLE;
         end
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Scaler handshake outputs decoded from state
   always_comb begin
      enable = 1'b0;
      wren   = 1'b0;
      busy   = 1'b0;
      case (state)
         S_PROCESS: begin
            enable = 1'b1;
            wren   = 1'b1;
            busy   = 1'b1;
         end
         S_DONE:    busy = 1'b1;
         default:   ;
      endcase
   end

   // Zoom level, sticky errors, watchdog counter and run-once flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zoom_level              <= RST_LEVEL;
         prev_level              <= RST_LEVEL;
         invalid_zoom_error      <= 1'b0;
         history_empty_error     <= 1'b0;
         timeout_error           <= 1'b0;
         processing_has_run_once <= 1'b0;
         wd_cnt                  <= '0;
      end else begin
         if (accept) begin
            prev_level          <= zoom_level;
            invalid_zoom_error  <= 1'b0;
            history_empty_error <= 1'b0;
            timeout_error       <= 1'b0;
            wd_cnt              <= '0;
            if (acc_in)       zoom_level <= zoom_level + LEVEL_W'(1);
            else if (acc_out) zoom_level <= zoom_level - LEVEL_W'(1);
            else              zoom_level <= top_data;
         end else begin
            if (mismatch)  invalid_zoom_error  <= 1'b1;
            if (empty_req) history_empty_error <= 1'b1;
         end
         if (state == S_PROCESS) begin
            if (done) begin
               processing_has_run_once <= 1'b1;
            end else if (timeout_hit) begin
               timeout_error <= 1'b1;
               zoom_level    <= prev_level;
            end else begin
               wd_cnt <= wd_cnt + WD_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_zoom_ctrl_hist.sv
// Directed self-checking bench for zoom_ctrl_hist (watchdog set to 8 cycles).
module tb_zoom_ctrl_hist;

   logic       clk = 1'b0;
   logic       reset;
   logic       zoom_in, zoom_out, return_to_previous;
   logic [1:0] algorithm_select;
   logic       multiple_switches_error, no_switch_selected_error;
   logic       done;
   logic       enable, wren, busy;
   logic [2:0] zoom_level;
   logic [2:0] history_count;
   logic       invalid_zoom_error, history_empty_error, timeout_error;
   logic       processing_has_run_once;

   int total = 0;
   int bad   = 0;

   logic [2:0] pop_exp [4] = '{3'd3, 3'd4, 3'd3, 3'd4};

   zoom_ctrl_hist #(
      .LEVEL_W        (3),
      .NUM_LEVELS     (5),
      .DEFAULT_LEVEL  (2),
      .HIST_DEPTH     (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .zoom_in                  (zoom_in),
      .zoom_out                 (zoom_out),
      .return_to_previous       (return_to_previous),
      .algorithm_select         (algorithm_select),
      .multiple_switches_error  (multiple_switches_error),
      .no_switch_selected_error (no_switch_selected_error),
      .done                     (done),
      .enable                   (enable),
      .wren                     (wren),
      .busy                     (busy),
      .zoom_level               (zoom_level),
      .history_count            (history_count),
      .invalid_zoom_error       (invalid_zoom_error),
      .history_empty_error      (history_empty_error),
      .timeout_error            (timeout_error),
      .processing_has_run_once  (processing_has_run_once)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Raise the chosen requests for one cycle; returns just after the edge that sees them
   task automatic press(input logic zi, input logic zo, input logic rp);
      zoom_in            = zi;
      zoom_out           = zo;
      return_to_previous = rp;
      tick();
      zoom_in            = 1'b0;
      zoom_out           = 1'b0;
      return_to_previous = 1'b0;
   endtask

   // Complete a PROCESS phase: done for one cycle, one DONE cycle, back to IDLE
   task automatic finish_op();
      done = 1'b1;
      tick();
      check("done_busy", busy, 1);
      check("done_enable", enable, 0);
      check("done_ran_once", processing_has_run_once, 1);
      done = 1'b0;
      tick();
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1'b1;
      zoom_in = 1'b0; zoom_out = 1'b0; return_to_previous = 1'b0;
      algorithm_select = 2'b00;
      multiple_switches_error = 1'b0; no_switch_selected_error = 1'b0;
      done = 1'b0;
      tick(); tick();

      // Reset values
      check("rst_level", zoom_level, 2);
      check("rst_hcount", history_count, 0);
      check("rst_enable", enable, 0);
      check("rst_wren", wren, 0);
      check("rst_busy", busy, 0);
      check("rst_errors", {invalid_zoom_error, history_empty_error, timeout_error}, 0);
      check("rst_ran_once", processing_has_run_once, 0);
      reset = 1'b0;
      tick();

      // 1: single zoom_in
      press(1, 0, 0);
      check("t1_level", zoom_level, 3);
      check("t1_hcount", history_count, 1);
      check("t1_enable", enable, 1);
      check("t1_wren", wren, 1);
      check("t1_busy", busy, 1);
      finish_op();

      // 2: zoom_in up to the top; extra requests ignored silently
      press(1, 0, 0);
      check("t2_level4", zoom_level, 4);
      finish_op();
      for (int i = 0; i < 4; i++) begin
         press(1, 0, 0);
         check("t2_limit_busy", busy, 0);
         check("t2_limit_level", zoom_level, 4);
         check("t2_limit_noerr", invalid_zoom_error, 0);
         tick();
      end
      check("t2_hcount", history_count, 2);
      press(0, 1, 0);
      check("t2_mismatch_err", invalid_zoom_error, 1);
      check("t2_mismatch_level", zoom_level, 4);
      check("t2_mismatch_busy", busy, 0);
      tick();

      // 3: six alternating ops fill the history, then unwind it
      for (int i = 0; i < 6; i++) begin
         algorithm_select = (i % 2 == 0) ? 2'b10 : 2'b00;
         press((i % 2) == 1, (i % 2) == 0, 0);
         check("t3_op_level", zoom_level, (i % 2 == 0) ? 3 : 4);
         if (i == 0) check("t3_err_cleared", invalid_zoom_error, 0);
         finish_op();
      end
      check("t3_full_count", history_count, 4);
      for (int i = 0; i < 4; i++) begin
         press(0, 0, 1);
         check("t3_pop_level", zoom_level, pop_exp[i]);
         check("t3_pop_count", history_count, 3 - i);
         finish_op();
      end
      press(0, 0, 1);
      check("t3_empty_err", history_empty_error, 1);
      check("t3_empty_busy", busy, 0);
      check("t3_empty_level", zoom_level, 4);
      tick();

      // 4: return beats zoom_in in the same cycle
      algorithm_select = 2'b10;
      press(0, 1, 0);
      check("t4_setup_level", zoom_level, 3);
      check("t4_setup_count", history_count, 1);
      finish_op();
      algorithm_select = 2'b00;
      press(1, 0, 1);
      check("t4_level", zoom_level, 4);
      check("t4_count", history_count, 0);
      check("t4_busy", busy, 1);
      finish_op();
      check("t4_level_after", zoom_level, 4);

      // Gate: no acceptance and no error change while a switch error is high
      algorithm_select = 2'b10;
      multiple_switches_error = 1'b1;
      press(0, 1, 0);
      check("gate_level", zoom_level, 4);
      check("gate_busy", busy, 0);
      tick();
      press(1, 0, 0);
      check("gate_noerr", invalid_zoom_error, 0);
      tick();
      multiple_switches_error = 1'b0;
      no_switch_selected_error = 1'b1;
      press(0, 1, 0);
      check("gate2_level", zoom_level, 4);
      tick();
      no_switch_selected_error = 1'b0;

      // 6: asynchronous reset in the middle of PROCESS
      press(0, 1, 0);
      check("t6_level", zoom_level, 3);
      check("t6_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("t6_enable", enable, 0);
      check("t6_wren", wren, 0);
      check("t6_busy_rst", busy, 0);
      check("t6_level_rst", zoom_level, 2);
      check("t6_count_rst", history_count, 0);
      tick();
      reset = 1'b0;
      tick();

      // 5: watchdog expires after 8 PROCESS cycles, push undone
      algorithm_select = 2'b00;
      press(1, 0, 0);
      check("t5_level", zoom_level, 3);
      check("t5_count", history_count, 1);
      for (int k = 2; k <= 8; k++) begin
         tick();
         check("t5_wait_busy", busy, 1);
      end
      tick();
      check("t5_timeout", timeout_error, 1);
      check("t5_level_restored", zoom_level, 2);
      check("t5_count_restored", history_count, 0);
      check("t5_busy", busy, 0);
      check("t5_enable", enable, 0);

      // done in the last watchdog cycle wins over the timeout
      press(1, 0, 0);
      check("t5b_err_cleared", timeout_error, 0);
      repeat (7) tick();
      done = 1'b1;
      tick();
      check("t5b_done_state", busy, 1);
      check("t5b_done_enable", enable, 0);
      check("t5b_no_timeout", timeout_error, 0);
      done = 1'b0;
      tick();
      check("t5b_idle", busy, 0);
      check("t5b_level", zoom_level, 3);
      check("t5b_count", history_count, 1);

      // Watchdog on a return: pop re-pushed
      press(0, 0, 1);
      check("t5c_pop_level", zoom_level, 2);
      check("t5c_pop_count", history_count, 0);
      repeat (8) tick();
      check("t5c_timeout", timeout_error, 1);
      check("t5c_level", zoom_level, 3);
      check("t5c_count", history_count, 1);
      press(0, 0, 1);
      check("t5c_repop_level", zoom_level, 2);
      check("t5c_repop_count", history_count, 0);
      finish_op();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
